// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter that sequences single-cycle accesses
// onto one single-port memory and returns results to the winner.
module mem_arbiter #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64,
  parameter int ADDR  = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             r0_valid_i,
  input  logic             r0_wr_rd_i,
  input  logic [ADDR-1:0]  r0_addr_i,
  input  logic [WIDTH-1:0] r0_wdata_i,
  output logic             r0_ready_o,
  output logic             r0_ack_o,
  output logic [WIDTH-1:0] r0_rdata_o,
  input  logic             r1_valid_i,
  input  logic             r1_wr_rd_i,
  input  logic [ADDR-1:0]  r1_addr_i,
  input  logic [WIDTH-1:0] r1_wdata_i,
  output logic             r1_ready_o,
  output logic             r1_ack_o,
  output logic [WIDTH-1:0] r1_rdata_o,
  output logic             mem_valid_o,
  output logic             mem_wr_rd_o,
  output logic [ADDR-1:0]  mem_addr_o,
  output logic [WIDTH-1:0] mem_write_o,
  input  logic [WIDTH-1:0] mem_read_i,
  input  logic             mem_ready_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t state;
  state_t state_d;

  logic last;
  logic last_d;
  logic owner;
  logic owner_d;
  logic any_req;
  logic pick1;

  logic             ready0_d;
  logic             ready1_d;
  logic             ack0_d;
  logic             ack1_d;
  logic [WIDTH-1:0] rdata0_d;
  logic [WIDTH-1:0] rdata1_d;
  logic             valid_d;
  logic             wr_rd_d;
  logic [ADDR-1:0]  addr_d;
  logic [WIDTH-1:0] write_d;

  // r1 wins outright when alone, or on a tie when r0 was granted last
  assign any_req = r0_valid_i | r1_valid_i;
  assign pick1   = r1_valid_i & (~r0_valid_i | ~last);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      last  <= 1'b1;
      owner <= 1'b0;
    end else begin
      state <= state_d;
      last  <= last_d;
      owner <= owner_d;
    end
  end

  always_comb begin
    state_d = state;
    last_d  = last;
    owner_d = owner;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          state_d = ISSUE;
          last_d  = pick1;
          owner_d = pick1;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (mem_ready_i) state_d = IDLE;
        else             state_d = ISSUE;
      end
      default: state_d = IDLE;
    endcase
  end

  // mem_wr_rd/addr/write double as the latched command registers
  always_comb begin
    ready0_d = 1'b0;
    ready1_d = 1'b0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = r0_rdata_o;
    rdata1_d = r1_rdata_o;
    valid_d  = 1'b0;
    wr_rd_d  = mem_wr_rd_o;
    addr_d   = mem_addr_o;
    write_d  = mem_write_o;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          valid_d  = 1'b1;
          ready0_d = ~pick1;
          ready1_d = pick1;
          wr_rd_d  = pick1 ? r1_wr_rd_i : r0_wr_rd_i;
          addr_d   = pick1 ? r1_addr_i  : r0_addr_i;
          write_d  = pick1 ? r1_wdata_i : r0_wdata_i;
        end
      end
      ISSUE: begin
        valid_d = 1'b0;
      end
      WAIT: begin
        if (mem_ready_i) begin
          ack0_d = ~owner;
          ack1_d = owner;
          if (!mem_wr_rd_o) begin
            if (owner) rdata1_d = mem_read_i;
            else       rdata0_d = mem_read_i;
          end
        end else begin
          valid_d = 1'b1;
        end
      end
      default: valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r0_ready_o  <= 1'b0;
      r1_ready_o  <= 1'b0;
      r0_ack_o    <= 1'b0;
      r1_ack_o    <= 1'b0;
      r0_rdata_o  <= '0;
      r1_rdata_o  <= '0;
      mem_valid_o <= 1'b0;
      mem_wr_rd_o <= 1'b0;
      mem_addr_o  <= '0;
      mem_write_o <= '0;
    end else begin
      r0_ready_o  <= ready0_d;
      r1_ready_o  <= ready1_d;
      r0_ack_o    <= ack0_d;
      r1_ack_o    <= ack1_d;
      r0_rdata_o  <= rdata0_d;
      r1_rdata_o  <= rdata1_d;
      mem_valid_o <= valid_d;
      mem_wr_rd_o <= wr_rd_d;
      mem_addr_o  <= addr_d;
      mem_write_o <= write_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port
// memory that can refuse one access to exercise the reissue path.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        r0_valid;
  logic        r0_wr_rd;
  logic [5:0]  r0_addr;
  logic [15:0] r0_wdata;
  logic        r0_ready;
  logic        r0_ack;
  logic [15:0] r0_rdata;
  logic        r1_valid;
  logic        r1_wr_rd;
  logic [5:0]  r1_addr;
  logic [15:0] r1_wdata;
  logic        r1_ready;
  logic        r1_ack;
  logic [15:0] r1_rdata;
  logic        mem_valid;
  logic        mem_wr_rd;
  logic [5:0]  mem_addr;
  logic [15:0] mem_write;
  logic [15:0] mem_read;
  logic        mem_ready;

  logic [15:0] mem [64];
  logic        drop;

  int checks;
  int errors;

  mem_arbiter #(.WIDTH(16), .DEPTH(64)) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .r0_valid_i(r0_valid),
    .r0_wr_rd_i(r0_wr_rd),
    .r0_addr_i(r0_addr),
    .r0_wdata_i(r0_wdata),
    .r0_ready_o(r0_ready),
    .r0_ack_o(r0_ack),
    .r0_rdata_o(r0_rdata),
    .r1_valid_i(r1_valid),
    .r1_wr_rd_i(r1_wr_rd),
    .r1_addr_i(r1_addr),
    .r1_wdata_i(r1_wdata),
    .r1_ready_o(r1_ready),
    .r1_ack_o(r1_ack),
    .r1_rdata_o(r1_rdata),
    .mem_valid_o(mem_valid),
    .mem_wr_rd_o(mem_wr_rd),
    .mem_addr_o(mem_addr),
    .mem_write_o(mem_write),
    .mem_read_i(mem_read),
    .mem_ready_i(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory samples valid at an edge and answers in the next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ready <= 1'b0;
      mem_read  <= '0;
    end else begin
      mem_ready <= 1'b0;
      if (mem_valid && !drop) begin
        mem_ready <= 1'b1;
        if (mem_wr_rd) mem[mem_addr] <= mem_write;
        else           mem_read <= mem[mem_addr];
      end
    end
  end

  task automatic do_reset();
    rst_n    = 1'b0;
    drop     = 1'b0;
    r0_valid = 1'b0;
    r0_wr_rd = 1'b0;
    r0_addr  = '0;
    r0_wdata = '0;
    r1_valid = 1'b0;
    r1_wr_rd = 1'b0;
    r1_addr  = '0;
    r1_wdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic xfer(input bit port, input bit wr,
                      input logic [5:0] a, input logic [15:0] d,
                      output int lat, output logic [15:0] rd);
    @(negedge clk);
    if (port) begin
      r1_valid = 1'b1; r1_wr_rd = wr; r1_addr = a; r1_wdata = d;
    end else begin
      r0_valid = 1'b1; r0_wr_rd = wr; r0_addr = a; r0_wdata = d;
    end
    lat = -1;
    rd  = 'x;
    for (int n = 1; n <= 20 && lat < 0; n++) begin
      @(negedge clk);
      if (!port && r0_ready) r0_valid = 1'b0;
      if (port && r1_ready)  r1_valid = 1'b0;
      if (!port && r0_ack) begin lat = n; rd = r0_rdata; end
      if (port && r1_ack)  begin lat = n; rd = r1_rdata; end
    end
    r0_valid = 1'b0;
    r1_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [75:0] outs;
    rst_n = 1'b0;
    #1;
    outs = {r0_ready, r1_ready, r0_ack, r1_ack, mem_valid, mem_wr_rd,
            mem_addr, mem_write, r0_rdata, r1_rdata};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", outs);
    end
    do_reset();
    @(negedge clk);
    outs = {r0_ready, r1_ready, r0_ack, r1_ack, mem_valid, mem_wr_rd,
            mem_addr, mem_write, r0_rdata, r1_rdata};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL idle_after_reset got %h want 0", outs);
    end
  endtask

  task automatic test_single_write();
    do_reset();
    @(negedge clk);
    r0_valid = 1'b1; r0_wr_rd = 1'b1; r0_addr = 6'd5; r0_wdata = 16'hA5A5;
    @(negedge clk);
    r0_valid = 1'b0;
    checks++;
    if ({r0_ready, r1_ready, mem_valid, mem_wr_rd} !== 4'b1011 ||
        mem_addr !== 6'd5 || mem_write !== 16'hA5A5) begin
      errors++;
      $display("FAIL wr_issue got rdy=%b%b v=%b w=%b a=%0d d=%h want 1 0 1 1 5 a5a5",
               r0_ready, r1_ready, mem_valid, mem_wr_rd, mem_addr, mem_write);
    end
    @(negedge clk);
    checks++;
    if ({r0_ready, mem_valid, r0_ack} !== 3'b000) begin
      errors++;
      $display("FAIL wr_wait got %b want 000", {r0_ready, mem_valid, r0_ack});
    end
    @(negedge clk);
    checks++;
    if ({r0_ack, r1_ack, r1_ready} !== 3'b100 || r1_rdata !== 16'h0) begin
      errors++;
      $display("FAIL wr_ack got %b r1d=%h want 100 0", {r0_ack, r1_ack, r1_ready}, r1_rdata);
    end
    @(negedge clk);
    checks++;
    if (r0_ack !== 1'b0) begin
      errors++;
      $display("FAIL wr_ack_pulse got %b want 0", r0_ack);
    end
  endtask

  task automatic test_read_after_write();
    int lat;
    logic [15:0] rd;
    do_reset();
    xfer(1'b0, 1'b1, 6'd5, 16'hA5A5, lat, rd);
    xfer(1'b1, 1'b0, 6'd5, 16'h0000, lat, rd);
    checks++;
    if (lat != 3 || rd !== 16'hA5A5) begin
      errors++;
      $display("FAIL raw_read got lat=%0d d=%h want 3 a5a5", lat, rd);
    end
    checks++;
    if (r0_rdata !== 16'h0) begin
      errors++;
      $display("FAIL raw_r0_untouched got %h want 0", r0_rdata);
    end
  endtask

  task automatic test_contention();
    logic [4:0] got;
    logic [4:0] exp;
    do_reset();
    @(negedge clk);
    r0_valid = 1'b1; r0_wr_rd = 1'b1; r0_addr = 6'd1; r0_wdata = 16'h1111;
    r1_valid = 1'b1; r1_wr_rd = 1'b1; r1_addr = 6'd2; r1_wdata = 16'h2222;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      got = {r0_ready, r1_ready, r0_ack, r1_ack, mem_valid};
      exp = {c == 1 || c == 7, c == 4 || c == 10,
             c == 3 || c == 9, c == 6 || c == 12, c % 3 == 1};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL contend_c%0d got %b want %b", c, got, exp);
      end
      if (c % 3 == 1) begin
        checks++;
        if (mem_addr !== ((c == 1 || c == 7) ? 6'd1 : 6'd2)) begin
          errors++;
          $display("FAIL contend_addr_c%0d got %0d", c, mem_addr);
        end
      end
    end
    r0_valid = 1'b0;
    r1_valid = 1'b0;
  endtask

  task automatic test_retry();
    logic [4:0] got;
    logic [4:0] exp;
    int lat;
    logic [15:0] rd;
    do_reset();
    @(negedge clk);
    drop = 1'b1;
    r1_valid = 1'b1; r1_wr_rd = 1'b1; r1_addr = 6'd9; r1_wdata = 16'hBEEF;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) r1_valid = 1'b0;
      if (c == 2) drop = 1'b0;
      got = {r1_ready, r1_ack, r0_ready, r0_ack, mem_valid};
      exp = {c == 1, c == 5, 1'b0, 1'b0, c == 1 || c == 3};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL retry_c%0d got %b want %b", c, got, exp);
      end
      if (c == 3) begin
        checks++;
        if (mem_addr !== 6'd9 || mem_write !== 16'hBEEF || mem_wr_rd !== 1'b1) begin
          errors++;
          $display("FAIL retry_cmd got a=%0d d=%h w=%b want 9 beef 1",
                   mem_addr, mem_write, mem_wr_rd);
        end
      end
    end
    xfer(1'b1, 1'b0, 6'd9, 16'h0, lat, rd);
    checks++;
    if (lat != 3 || rd !== 16'hBEEF) begin
      errors++;
      $display("FAIL retry_readback got lat=%0d d=%h want 3 beef", lat, rd);
    end
  endtask

  task automatic test_reset_mid_op();
    int acks;
    do_reset();
    @(negedge clk);
    r0_valid = 1'b1; r0_wr_rd = 1'b1; r0_addr = 6'd7; r0_wdata = 16'h7777;
    @(negedge clk);
    checks++;
    if ({r0_ready, mem_valid} !== 2'b11) begin
      errors++;
      $display("FAIL midrst_issue got %b want 11", {r0_ready, mem_valid});
    end
    #1 rst_n = 1'b0;
    r0_valid = 1'b0;
    #1;
    checks++;
    if ({r0_ready, mem_valid, mem_wr_rd, mem_addr, mem_write} !== '0) begin
      errors++;
      $display("FAIL midrst_clear got rdy=%b v=%b a=%0d d=%h want 0",
               r0_ready, mem_valid, mem_addr, mem_write);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      acks += int'(r0_ack) + int'(r1_ack) + int'(mem_valid);
    end
    checks++;
    if (acks != 0) begin
      errors++;
      $display("FAIL midrst_no_ack got %0d want 0", acks);
    end
    r0_valid = 1'b1; r0_wr_rd = 1'b1; r0_addr = 6'd10; r0_wdata = 16'h1010;
    r1_valid = 1'b1; r1_wr_rd = 1'b1; r1_addr = 6'd11; r1_wdata = 16'h1111;
    @(negedge clk);
    checks++;
    if ({r0_ready, r1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL midrst_tie got %b want 10", {r0_ready, r1_ready});
    end
    r0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({r0_ack, r1_ack} !== 2'b10) begin
      errors++;
      $display("FAIL midrst_ack0 got %b want 10", {r0_ack, r1_ack});
    end
    @(negedge clk);
    checks++;
    if (r1_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_r1_grant got %b want 1", r1_ready);
    end
    r1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (r1_ack !== 1'b1) begin
      errors++;
      $display("FAIL midrst_ack1 got %b want 1", r1_ack);
    end
  endtask

  task automatic test_boundaries();
    int lat;
    logic [15:0] rd;
    do_reset();
    xfer(1'b0, 1'b1, 6'd0, 16'hFFFF, lat, rd);
    xfer(1'b1, 1'b1, 6'd63, 16'h0001, lat, rd);
    xfer(1'b0, 1'b0, 6'd0, 16'h0, lat, rd);
    checks++;
    if (rd !== 16'hFFFF) begin
      errors++;
      $display("FAIL bound_addr0 got %h want ffff", rd);
    end
    xfer(1'b1, 1'b0, 6'd63, 16'h0, lat, rd);
    checks++;
    if (rd !== 16'h0001) begin
      errors++;
      $display("FAIL bound_addr63 got %h want 0001", rd);
    end
    xfer(1'b0, 1'b1, 6'd0, 16'h1234, lat, rd);
    xfer(1'b1, 1'b1, 6'd63, 16'h4321, lat, rd);
    checks++;
    if (r0_rdata !== 16'hFFFF || r1_rdata !== 16'h0001) begin
      errors++;
      $display("FAIL bound_hold got %h %h want ffff 0001", r0_rdata, r1_rdata);
    end
    xfer(1'b0, 1'b0, 6'd0, 16'h0, lat, rd);
    checks++;
    if (rd !== 16'h1234 || r1_rdata !== 16'h0001) begin
      errors++;
      $display("FAIL bound_reread got %h %h want 1234 0001", rd, r1_rdata);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    do_reset();
    test_reset();
    test_single_write();
    test_read_after_write();
    test_contention();
    test_retry();
    test_reset_mid_op();
    test_boundaries();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
